// File: rtl/switch_press_detector_pkg.sv
// Shared board constants for the GoBoard push-button front end.
package switch_press_detector_pkg;

  localparam int CLK_HZ = 25_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEF_DEBOUNCE_LIMIT = ms_to_cycles(10);
  localparam int DEF_REPEAT_DELAY   = ms_to_cycles(500);
  localparam int DEF_REPEAT_RATE    = ms_to_cycles(100);

endpackage

// File: rtl/switch_press_detector_debounce_core.sv
// Two-flop synchronizer plus debounce counter. o_Level is the accepted
// level; o_Change strobes for one cycle on the clock edge that flips it.
module switch_press_detector_debounce_core
  import switch_press_detector_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Change
);

  localparam int DB_W = $clog2(DEBOUNCE_LIMIT);
  localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_LIMIT - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            accept;

  // Accept when the synchronized level has differed for the full window.
  assign accept = (sync2_q != stable_q) && (db_cnt_q == DB_TC);

  // Next-state for the debounce counter and stable level.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (accept) begin
      stable_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Synchronizer and debounce registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= i_Switch;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign o_Level  = stable_q;
  assign o_Change = accept;

endmodule

// File: rtl/switch_press_detector.sv
// Debounced push-button with single-cycle press/release pulses and
// optional hold-to-repeat.
//
// state  | meaning
// IDLE   | released, or repeat disabled
// DELAY  | pressed, waiting for the first repeat
// REPEAT | held, emitting a press every REPEAT_RATE cycles
module switch_press_detector
  import switch_press_detector_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Held
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [REP_W-1:0] DELAY_TC = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_TC  = REP_W'(REPEAT_RATE - 1);

  logic             level;
  logic             change;
  logic             rise, fall;
  rep_state_e       state_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic             press_q, release_q;

  switch_press_detector_debounce_core #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch),
    .o_Level (level),
    .o_Change(change)
  );

  // change is the acceptance strobe, so the pulse registers line up with
  // the cycle where o_Switch first shows the new level.
  assign rise = change & ~level;
  assign fall = change & level;

  // Repeat FSM with registered pulses; a release always beats a repeat.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      rep_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (fall) begin
        release_q <= 1'b1;
        state_q   <= ST_IDLE;
        rep_cnt_q <= '0;
      end else if (rise) begin
        press_q   <= 1'b1;
        rep_cnt_q <= '0;
        if (REPEAT_EN != 0) state_q <= ST_DELAY;
      end else begin
        case (state_q)
          ST_DELAY: begin
            if (rep_cnt_q == DELAY_TC) begin
              press_q   <= 1'b1;
              state_q   <= ST_REPEAT;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (rep_cnt_q == RATE_TC) begin
              press_q   <= 1'b1;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign o_Switch  = level;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Held    = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_switch_press_detector.sv
// Bench for switch_press_detector: one instance with repeat enabled, one
// with it disabled, both driven by the same switch.
module tb_switch_press_detector;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk;
  logic rst_n;
  logic sw;
  logic [1:0] d_sw, d_press, d_rel, d_held;

  int checks = 0;
  int errors = 0;

  switch_press_detector #(
    .DEBOUNCE_LIMIT(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) u_dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
    .o_Switch(d_sw[0]), .o_Press(d_press[0]), .o_Release(d_rel[0]), .o_Held(d_held[0])
  );

  switch_press_detector #(
    .DEBOUNCE_LIMIT(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) u_dut_norep (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
    .o_Switch(d_sw[1]), .o_Press(d_press[1]), .o_Release(d_rel[1]), .o_Held(d_held[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the raw input reaches the debouncer two edges late,
  // a level is accepted after DB consecutive differing samples, and repeats
  // are placed by elapsed time since the accepted press.
  bit m_s1[2], m_s2[2], m_stable[2], m_pressed[2];
  bit m_press[2], m_rel[2], m_held[2];
  int m_run[2], m_pedge[2];
  int cyc = 0;

  always @(posedge clk) begin : model
    bit chg;
    bit en;
    int dt;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_pressed[i] = 0;
        m_press[i] = 0; m_rel[i] = 0; m_held[i] = 0;
        m_run[i] = 0; m_pedge[i] = 0;
      end
      cyc = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        en  = (i == 0);
        chg = 0;
        if (m_s2[i] != m_stable[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DB) begin
          m_stable[i] = m_s2[i];
          m_run[i] = 0;
          chg = 1;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = sw;
        m_press[i] = 0;
        m_rel[i] = 0;
        if (chg && m_stable[i]) begin
          m_press[i] = 1; m_pressed[i] = 1; m_pedge[i] = cyc;
        end else if (chg) begin
          m_rel[i] = 1; m_pressed[i] = 0;
        end else if (m_pressed[i] && en) begin
          dt = cyc - m_pedge[i];
          if (dt >= RD && ((dt - RD) % RR) == 0) m_press[i] = 1;
        end
        m_held[i] = m_pressed[i] && en && ((cyc - m_pedge[i]) >= RD);
      end
      cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        check($sformatf("rst u%0d.o_Switch", i), d_sw[i], 0);
        check($sformatf("rst u%0d.o_Press", i), d_press[i], 0);
        check($sformatf("rst u%0d.o_Release", i), d_rel[i], 0);
        check($sformatf("rst u%0d.o_Held", i), d_held[i], 0);
      end else begin
        check($sformatf("u%0d.o_Switch", i), d_sw[i], m_stable[i]);
        check($sformatf("u%0d.o_Press", i), d_press[i], m_press[i]);
        check($sformatf("u%0d.o_Release", i), d_rel[i], m_rel[i]);
        check($sformatf("u%0d.o_Held", i), d_held[i], m_held[i]);
        check($sformatf("u%0d.excl", i), d_press[i] & d_rel[i], 0);
      end
    end
  end

  int acc_press[2], acc_rel[2], acc_held[2], acc_sw[2];

  task automatic clear_acc();
    for (int i = 0; i < 2; i++) begin
      acc_press[i] = 0; acc_rel[i] = 0; acc_held[i] = 0; acc_sw[i] = 0;
    end
  endtask

  // Drive v, then observe n cycles (one per clock edge) accumulating activity.
  task automatic hold(input bit v, input int n);
    sw = v;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        acc_press[i] += int'(d_press[i]);
        acc_rel[i]   += int'(d_rel[i]);
        acc_held[i]  += int'(d_held[i]);
        acc_sw[i]    += int'(d_sw[i]);
      end
    end
  endtask

  logic [31:0] mask;
  int first_held;

  initial begin
    rst_n = 1'b0;
    sw    = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_state u%0d", i),
            int'({d_sw[i], d_press[i], d_rel[i], d_held[i]}), 0);
    end
    #3 rst_n = 1'b1;
    hold(0, 5);

    // Clean press: press on edge 5 after E0, repeats at 15,18,21,24,27.
    clear_acc();
    sw = 1'b1;
    mask = '0;
    first_held = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (d_press[0]) mask[k] = 1'b1;
      if (d_held[0] && first_held < 0) first_held = k;
      acc_press[1] += int'(d_press[1]);
    end
    check("clean_press_edges", int'(mask), 32'h0924_8020);
    check("clean_first_held", first_held, 15);
    check("clean_norep_presses", acc_press[1], 1);

    // Release timed so acceptance lands on the repeat at edge 36.
    @(negedge clk);
    check("repeat_edge30", d_press[0], 1);
    sw = 1'b0;
    for (int k = 31; k <= 36; k++) begin
      @(negedge clk);
      if (k == 33) check("repeat_edge33", d_press[0], 1);
    end
    check("tie_release", d_rel[0], 1);
    check("tie_no_press", d_press[0], 0);
    check("tie_held_low", d_held[0], 0);
    hold(0, 10);

    // Bounce: 2-cycle toggles never accepted, then a clean rise.
    clear_acc();
    hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 2);
    sw = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc_press[0] += int'(d_press[0]);
      acc_sw[0]    += int'(d_sw[0]);
    end
    check("bounce_quiet_press", acc_press[0], 0);
    check("bounce_quiet_level", acc_sw[0], 0);
    @(negedge clk);
    check("bounce_press", d_press[0], 1);
    check("bounce_level", d_sw[0], 1);

    // Reset while in REPEAT with the switch still held.
    hold(1, 12);
    check("pre_reset_held", d_held[0], 1);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async_reset u%0d", i),
            int'({d_sw[i], d_press[i], d_rel[i], d_held[i]}), 0);
    end
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    clear_acc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc_press[0] += int'(d_press[0]);
      acc_press[1] += int'(d_press[1]);
    end
    check("post_reset_quiet", acc_press[0] + acc_press[1], 0);
    @(negedge clk);
    check("post_reset_press_u0", d_press[0], 1);
    check("post_reset_press_u1", d_press[1], 1);
    hold(0, 12);

    // Short glitch: three cycles high.
    clear_acc();
    hold(1, 3);
    hold(0, 15);
    check("glitch_level", acc_sw[0] + acc_sw[1], 0);
    check("glitch_press", acc_press[0] + acc_press[1], 0);
    check("glitch_release", acc_rel[0] + acc_rel[1], 0);

    // Long hold: one press without repeat, ten presses with repeat.
    clear_acc();
    hold(1, 40);
    check("norep_presses", acc_press[1], 1);
    check("norep_held", acc_held[1], 0);
    check("rep_presses", acc_press[0], 10);
    clear_acc();
    hold(0, 10);
    check("norep_release", acc_rel[1], 1);
    check("rep_release", acc_rel[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
